// File: rtl/mem_access_unit_pkg.sv
// Shared types and RV32I load/store funct3 encodings for the memory access unit.
`timescale 1ns/1ps
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Wishbone pipelined data-port bus between the load/store unit and main memory.
`timescale 1ns/1ps
interface mem_access_if #(parameter int ADDR_WIDTH = 10);

    logic                  wb_cyc;
    logic                  wb_stb;
    logic                  wb_wr_en;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [31:0]           wb_wr_data;
    logic [3:0]            wb_wr_sel;
    logic                  wb_ack;
    logic                  wb_stall;
    logic [31:0]           wb_rd_data;

    modport master (
        output wb_cyc, wb_stb, wb_wr_en, wb_addr, wb_wr_data, wb_wr_sel,
        input  wb_ack, wb_stall, wb_rd_data
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_wr_en, wb_addr, wb_wr_data, wb_wr_sel,
        output wb_ack, wb_stall, wb_rd_data
    );

endinterface

// File: rtl/mem_access_unit_align.sv
// Byte-lane steering: store lane enables/replicated data, load extraction and
// extension, and detection of misaligned or illegal funct3 encodings.
`timescale 1ns/1ps
module mem_align
    import mem_access_pkg::*;
(
    input  logic        wr_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wr_data_i,
    input  logic [31:0] rd_word_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wr_lane_o,
    output logic [31:0] rd_fmt_o,
    output logic        misaligned_o
);

    logic [31:0] shifted;

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        sel_o        = '0;
        wr_lane_o    = '0;
        rd_fmt_o     = '0;
        misaligned_o = 1'b0;
        shifted      = rd_word_i >> {addr_lo_i, 3'b000};
        if (wr_i) begin
            case (funct3_i)
                F3_B: begin
                    sel_o     = 4'b0001 << addr_lo_i;
                    wr_lane_o = {4{wr_data_i[7:0]}};
                end
                F3_H: begin
                    sel_o        = 4'b0011 << {addr_lo_i[1], 1'b0};
                    wr_lane_o    = {2{wr_data_i[15:0]}};
                    misaligned_o = addr_lo_i[0];
                end
                F3_W: begin
                    sel_o        = 4'b1111;
                    wr_lane_o    = wr_data_i;
                    misaligned_o = |addr_lo_i;
                end
                default: misaligned_o = 1'b1;
            endcase
        end else begin
            case (funct3_i)
                F3_B:  rd_fmt_o = {{24{shifted[7]}}, shifted[7:0]};
                F3_BU: rd_fmt_o = {24'h0, shifted[7:0]};
                F3_H: begin
                    rd_fmt_o     = {{16{shifted[15]}}, shifted[15:0]};
                    misaligned_o = addr_lo_i[0];
                end
                F3_HU: begin
                    rd_fmt_o     = {16'h0, shifted[15:0]};
                    misaligned_o = addr_lo_i[0];
                end
                F3_W: begin
                    rd_fmt_o     = shifted;
                    misaligned_o = |addr_lo_i;
                end
                default: misaligned_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: Wishbone pipelined master that stalls the pipeline
// until each access completes, with ack timeout and misalignment reporting.
`timescale 1ns/1ps
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    input  logic        i_wr,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wr_data,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_rd_data,
    output logic        o_misaligned,
    output logic        o_bus_err,
    mem_access_if.master wb
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            alo_q, alo_d;
    logic                  cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            sel_q, sel_d;
    logic                  done_q, done_d, mis_q, mis_d, err_q, err_d;
    logic [31:0]           rd_q, rd_d;

    logic                  use_in;
    logic [3:0]            al_sel;
    logic [31:0]           al_lane, al_rd;
    logic                  al_mis;
    logic                  unused_addr_hi;

    assign unused_addr_hi = ^i_addr[31:ADDR_WIDTH];

    // The aligner sees the incoming request while accepting, the latched one afterwards.
    assign use_in = (state_q == IDLE);

    mem_align u_align (
        .wr_i         (use_in ? i_wr : wr_q),
        .funct3_i     (use_in ? i_funct3 : f3_q),
        .addr_lo_i    (use_in ? i_addr[1:0] : alo_q),
        .wr_data_i    (i_wr_data),
        .rd_word_i    (wb.wb_rd_data),
        .sel_o        (al_sel),
        .wr_lane_o    (al_lane),
        .rd_fmt_o     (al_rd),
        .misaligned_o (al_mis)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        f3_d    = f3_q;
        alo_d   = alo_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        rd_d    = rd_q;
        done_d  = 1'b0;
        mis_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (i_valid) begin
                wr_d  = i_wr;
                f3_d  = i_funct3;
                alo_d = i_addr[1:0];
                if (al_mis) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    mis_d   = 1'b1;
                    rd_d    = '0;
                end else begin
                    state_d = REQ;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = i_wr;
                    addr_d  = {i_addr[ADDR_WIDTH-1:2], 2'b00};
                    wdata_d = al_lane;
                    sel_d   = al_sel;
                end
            end
            REQ: if (!wb.wb_stall) begin
                stb_d = 1'b0;
                cnt_d = '0;
                if (wb.wb_ack) begin
                    cyc_d   = 1'b0;
                    state_d = DONE;
                    done_d  = 1'b1;
                    if (!wr_q) rd_d = al_rd;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (wb.wb_ack) begin
                    cyc_d   = 1'b0;
                    state_d = DONE;
                    done_d  = 1'b1;
                    if (!wr_q) rd_d = al_rd;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    cyc_d   = 1'b0;
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    rd_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            f3_q    <= '0;
            alo_q   <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            rd_q    <= '0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            f3_q    <= f3_d;
            alo_q   <= alo_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
        end
    end

    assign o_stall       = i_valid && (state_q != DONE);
    assign o_done        = done_q;
    assign o_rd_data     = rd_q;
    assign o_misaligned  = mis_q;
    assign o_bus_err     = err_q;
    assign wb.wb_cyc     = cyc_q;
    assign wb.wb_stb     = stb_q;
    assign wb.wb_wr_en   = we_q;
    assign wb.wb_addr    = addr_q;
    assign wb.wb_wr_data = wdata_q;
    assign wb.wb_wr_sel  = sel_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: 1-cycle-ack memory slave with stall/no-ack injection and a
// completion scoreboard checked by an independent monitor.
`timescale 1ns/1ps
module tb_mem_access_unit;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0, i_wr = 1'b0;
    logic [2:0]  i_funct3 = '0;
    logic [31:0] i_addr = '0, i_wr_data = '0;
    logic        o_stall, o_done, o_misaligned, o_bus_err;
    logic [31:0] o_rd_data;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];
    exp_t e;

    // Slave-side state
    logic [31:0] mem [256];
    int          stall_len = 0;
    logic        noack = 1'b0;
    int          stall_seen, cyc_cnt, stb_cnt, unstable;
    logic [9:0]  last_addr, prev_addr;
    logic [31:0] last_wdata, prev_wdata;
    logic [3:0]  last_sel, prev_sel;
    logic        prev_stb;

    mem_access_if #(.ADDR_WIDTH(10)) bus ();

    mem_access_unit #(.ADDR_WIDTH(10), .TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_valid      (i_valid),
        .i_wr         (i_wr),
        .i_funct3     (i_funct3),
        .i_addr       (i_addr),
        .i_wr_data    (i_wr_data),
        .o_stall      (o_stall),
        .o_done       (o_done),
        .o_rd_data    (o_rd_data),
        .o_misaligned (o_misaligned),
        .o_bus_err    (o_bus_err),
        .wb           (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.wb_stall = bus.wb_stb && (stall_seen < stall_len);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wb_ack     <= 1'b0;
            bus.wb_rd_data <= '0;
            stall_seen     <= 0;
            prev_stb       <= 1'b0;
        end else begin
            bus.wb_ack <= 1'b0;
            if (bus.wb_cyc) cyc_cnt <= cyc_cnt + 1;
            if (bus.wb_stb) stb_cnt <= stb_cnt + 1;
            if (bus.wb_stb && prev_stb &&
                (bus.wb_addr != prev_addr || bus.wb_wr_sel != prev_sel || bus.wb_wr_data != prev_wdata))
                unstable <= unstable + 1;
            prev_stb   <= bus.wb_stb;
            prev_addr  <= bus.wb_addr;
            prev_sel   <= bus.wb_wr_sel;
            prev_wdata <= bus.wb_wr_data;
            if (bus.wb_stb && bus.wb_stall) stall_seen <= stall_seen + 1;
            else if (!bus.wb_stb) stall_seen <= 0;
            if (bus.wb_cyc && bus.wb_stb && !bus.wb_stall) begin
                last_addr  <= bus.wb_addr;
                last_sel   <= bus.wb_wr_sel;
                last_wdata <= bus.wb_wr_data;
                if (!noack) begin
                    bus.wb_ack     <= 1'b1;
                    bus.wb_rd_data <= mem[bus.wb_addr[9:2]];
                    if (bus.wb_wr_en)
                        for (int b = 0; b < 4; b++)
                            if (bus.wb_wr_sel[b]) mem[bus.wb_addr[9:2]][8*b +: 8] <= bus.wb_wr_data[8*b +: 8];
                end
            end
        end
    end

    initial begin
        cyc_cnt = 0; stb_cnt = 0; unstable = 0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Completion monitor: every o_done pops one expected response.
    always @(negedge clk) begin
        if (rst_n && o_done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("rd_data", o_rd_data, e.rd);
                check("misaligned", {31'd0, o_misaligned}, {31'd0, e.mis});
                check("bus_err", {31'd0, o_bus_err}, {31'd0, e.err});
            end
        end
    end

    task automatic do_op(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] exp_rd, input logic exp_mis,
                         input logic exp_err, input int exp_lat, input int exp_cyc);
        int lat, c0;
        @(negedge clk);
        i_valid = 1'b1; i_wr = wr; i_funct3 = f3; i_addr = addr; i_wr_data = data;
        sb.push_back('{rd: exp_rd, mis: exp_mis, err: exp_err});
        c0 = cyc_cnt;
        #1 check("stall_on_accept", {31'd0, o_stall}, 32'd1);
        lat = 0;
        for (int k = 0; k < 64; k++) begin
            @(posedge clk); #1;
            lat = k + 1;
            if (o_done) break;
        end
        if (!o_done) check("done_timeout", 32'd0, 32'd1);
        check("latency", lat, exp_lat);
        check("cyc_cycles", cyc_cnt - c0, exp_cyc);
        @(negedge clk);
        check("stall_in_done", {31'd0, o_stall}, 32'd0);
        i_valid = 1'b0;
    endtask

    initial begin
        #3;
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_rd", o_rd_data, 32'd0);
        check("rst_cyc", {31'd0, bus.wb_cyc}, 32'd0);
        check("rst_stb", {31'd0, bus.wb_stb}, 32'd0);
        check("rst_sel", {28'd0, bus.wb_wr_sel}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // SW then SB into word 4
        do_op(1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 3, 2);
        check("sw_sel", {28'd0, last_sel}, 32'hF);
        check("sw_addr", {22'd0, last_addr}, 32'h010);
        check("sw_data", last_wdata, 32'hDEADBEEF);
        check("sw_mem", mem[4], 32'hDEADBEEF);
        do_op(1'b1, 3'b000, 32'h013, 32'h000000A5, 32'h0, 1'b0, 1'b0, 3, 2);
        check("sb_sel", {28'd0, last_sel}, 32'h8);
        check("sb_data", last_wdata, 32'hA5A5A5A5);
        check("sb_mem", mem[4], 32'hA5ADBEEF);

        // Byte/word loads from word 0xA5ADBEEF
        do_op(1'b0, 3'b000, 32'h013, 32'h0, 32'hFFFFFFA5, 1'b0, 1'b0, 3, 2);
        do_op(1'b0, 3'b100, 32'h013, 32'h0, 32'h000000A5, 1'b0, 1'b0, 3, 2);
        do_op(1'b0, 3'b010, 32'h010, 32'h0, 32'hA5ADBEEF, 1'b0, 1'b0, 3, 2);

        // Halfword loads from word 0x80017F00; o_rd_data holds across the store
        do_op(1'b1, 3'b010, 32'h010, 32'h80017F00, 32'hA5ADBEEF, 1'b0, 1'b0, 3, 2);
        do_op(1'b0, 3'b001, 32'h012, 32'h0, 32'hFFFF8001, 1'b0, 1'b0, 3, 2);
        do_op(1'b0, 3'b101, 32'h012, 32'h0, 32'h00008001, 1'b0, 1'b0, 3, 2);

        // Misaligned and illegal encodings never touch the bus
        do_op(1'b0, 3'b001, 32'h011, 32'h0, 32'h0, 1'b1, 1'b0, 1, 0);
        do_op(1'b1, 3'b011, 32'h010, 32'h0, 32'h0, 1'b1, 1'b0, 1, 0);
        do_op(1'b0, 3'b110, 32'h010, 32'h0, 32'h0, 1'b1, 1'b0, 1, 0);
        do_op(1'b1, 3'b010, 32'h012, 32'h0, 32'h0, 1'b1, 1'b0, 1, 0);

        // Slave stall for 3 cycles in REQ
        begin
            int s0, u0;
            stall_len = 3;
            s0 = stb_cnt; u0 = unstable;
            do_op(1'b0, 3'b001, 32'h010, 32'h0, 32'h00007F00, 1'b0, 1'b0, 6, 5);
            check("stall_stb_cycles", stb_cnt - s0, 32'd4);
            check("stall_stable", unstable - u0, 32'd0);
            stall_len = 0;
        end

        do_op(1'b1, 3'b001, 32'h016, 32'h00001234, 32'h00007F00, 1'b0, 1'b0, 3, 2);
        check("sh_sel", {28'd0, last_sel}, 32'hC);
        check("sh_data", last_wdata, 32'h12341234);

        // Ack timeout: REQ plus 16 WAIT cycles with cyc high
        noack = 1'b1;
        do_op(1'b0, 3'b010, 32'h020, 32'h0, 32'h0, 1'b0, 1'b1, 18, 17);

        // Asynchronous reset in WAIT abandons the access
        @(negedge clk);
        i_valid = 1'b1; i_wr = 1'b0; i_funct3 = 3'b010; i_addr = 32'h010;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_cyc", {31'd0, bus.wb_cyc}, 32'd0);
        check("rst_mid_stb", {31'd0, bus.wb_stb}, 32'd0);
        i_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mid_done", {31'd0, o_done}, 32'd0);
        rst_n = 1'b1;
        noack = 1'b0;

        do_op(1'b0, 3'b010, 32'h010, 32'h0, 32'h80017F00, 1'b0, 1'b0, 3, 2);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
